// File: rtl/mux_arb_n.sv
// ---------------------------------------------------------------------------
// mux_arb_n
//
// N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready
// handshakes. One output register with back-pressure sits behind a grant
// stage that works in fixed-select or round-robin mode.
//
// Optional feature macro: MUX_RR_EN
//   defined   : round-robin pointer and search logic are built; mode_i
//               selects fixed (0) or round-robin (1) arbitration.
//   undefined : fixed-select only; mode_i is ignored. Ports are unchanged.
//
// Parameters
//   WIDTH   data width per channel
//   NUM_CH  number of input channels (>= 2)
//   SEL_W   width of a channel index
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   data_i   packed channel data, channel k at data_i[k*WIDTH +: WIDTH]
//   valid_i  per-channel valid
//   ready_o  per-channel ready, one-hot or zero
//   sel_i    channel select used in fixed mode
//   mode_i   0 = fixed select, 1 = round-robin
//   y_o      registered output data
//   valid_o  output valid
//   ready_i  downstream ready
//   ch_o     channel index of the word held in y_o
// ---------------------------------------------------------------------------
module mux_arb_n #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH*WIDTH-1:0] data_i,
  input  logic [NUM_CH-1:0]       valid_i,
  output logic [NUM_CH-1:0]       ready_o,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic                    mode_i,
  output logic [WIDTH-1:0]        y_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [SEL_W-1:0]        ch_o
);

  logic             load;
  logic             grant;
  logic [SEL_W-1:0] gnt_idx;
  logic             fix_grant;
  logic [WIDTH-1:0] data_sel;

  // The output register can accept a word when empty or being drained.
  assign load = ~valid_o | ready_i;

  // Fixed-mode grant: an out-of-range select matches no channel and so
  // never grants.
  always_comb begin
    fix_grant = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_i == SEL_W'(k)) begin
        fix_grant = valid_i[k];
      end
    end
  end

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] ptr;
  logic             rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W:0]   cand;

  // Round-robin search: first valid channel at or after ptr, wrapping.
  // cand is one bit wider so ptr+i cannot overflow before the wrap.
  always_comb begin
    rr_grant = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(NUM_CH)) begin
        cand = cand - (SEL_W+1)'(NUM_CH);
      end
      if (!rr_grant && valid_i[cand[SEL_W-1:0]]) begin
        rr_grant = 1'b1;
        rr_idx   = cand[SEL_W-1:0];
      end
    end
  end

  assign grant   = mode_i ? rr_grant : fix_grant;
  assign gnt_idx = mode_i ? rr_idx   : sel_i;

  // The pointer advances past the granted channel on every transfer,
  // in either mode, so switching to round-robin continues fairly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (load && grant) begin
      ptr <= (gnt_idx == SEL_W'(NUM_CH-1)) ? '0 : gnt_idx + SEL_W'(1);
    end
  end
`else
  logic unused_mode;

  assign unused_mode = mode_i;
  assign grant       = fix_grant;
  assign gnt_idx     = sel_i;
`endif

  // Data select for the granted channel.
  always_comb begin
    data_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        data_sel = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready goes only to the granted channel and never depends on data_i.
  assign ready_o = (load && grant) ? (NUM_CH'(1) << gnt_idx) : '0;

  // Output stage: capture on a transfer, go empty when free with no grant,
  // otherwise hold. Drain and load share one edge, so there is no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_o     <= '0;
      ch_o    <= '0;
      valid_o <= 1'b0;
    end else if (load) begin
      if (grant) begin
        y_o     <= data_sel;
        ch_o    <= gnt_idx;
        valid_o <= 1'b1;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_n
//
// Self-checking bench for mux_arb_n with NUM_CH=4, WIDTH=8. Works in both
// builds: with MUX_RR_EN undefined the reference model ignores mode_i.
// ---------------------------------------------------------------------------
module tb_mux_arb_n;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

`ifdef MUX_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic                    clk;
  logic                    reset_n;
  logic [NUM_CH*WIDTH-1:0] data_i;
  logic [NUM_CH-1:0]       valid_i;
  logic [NUM_CH-1:0]       ready_o;
  logic [SEL_W-1:0]        sel_i;
  logic                    mode_i;
  logic [WIDTH-1:0]        y_o;
  logic                    valid_o;
  logic                    ready_i;
  logic [SEL_W-1:0]        ch_o;

  mux_arb_n #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sel_i   (sel_i),
    .mode_i  (mode_i),
    .y_o     (y_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .ch_o    (ch_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [1:0]  sel;
    logic        rdy;
    logic [31:0] data;
    logic [3:0]  e_ready;
    logic [7:0]  e_y;
    logic        e_v;
    logic [1:0]  e_ch;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic       v;
    logic [1:0] ch;
    string      tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  vec_t none;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_y;
  logic       m_valid;
  logic [1:0] m_ch;
  int         m_ptr;

  task automatic modelReset();
    m_y     = 8'h00;
    m_valid = 1'b0;
    m_ch    = 2'd0;
    m_ptr   = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check ready_o, queue the expected register
  // contents, clock, then pop and compare.
  task automatic applyStimulus(input logic [3:0] v, input logic [1:0] s, input logic m,
                               input logic r, input logic [31:0] d, input string tag,
                               input bit useTab, input vec_t tv);
    bit         load;
    bit         gnt;
    int         g;
    int         k;
    logic [3:0] expReady;
    exp_t       nxt;
    exp_t       got;
    valid_i = v;
    sel_i   = s;
    mode_i  = m;
    ready_i = r;
    data_i  = d;
    load = !m_valid || r;
    gnt  = 1'b0;
    g    = 0;
    if (m && RR_EN) begin
      for (int off = 0; off < 4; off++) begin
        k = (m_ptr + off) % 4;
        if (!gnt && v[k]) begin
          gnt = 1'b1;
          g   = k;
        end
      end
    end else if (v[s]) begin
      gnt = 1'b1;
      g   = int'(s);
    end
    expReady = (load && gnt) ? (4'b0001 << g) : 4'b0000;
    nxt.y = m_y;  nxt.v = m_valid;  nxt.ch = m_ch;  nxt.tag = tag;
    if (load) begin
      if (gnt) begin
        nxt.y  = d[g*8 +: 8];
        nxt.v  = 1'b1;
        nxt.ch = 2'(g);
        m_ptr  = (g == 3) ? 0 : g + 1;
      end else begin
        nxt.v = 1'b0;
      end
    end
    m_y = nxt.y;  m_valid = nxt.v;  m_ch = nxt.ch;
    if (useTab) begin
      expReady = tv.e_ready;
      nxt.y    = tv.e_y;
      nxt.v    = tv.e_v;
      nxt.ch   = tv.e_ch;
    end
    #1;
    checkOutput({tag, ".ready"}, 32'(ready_o), 32'(expReady));
    sb.push_back(nxt);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput({got.tag, ".y"},     32'(y_o),     32'(got.y));
    checkOutput({got.tag, ".valid"}, 32'(valid_o), 32'(got.v));
    checkOutput({got.tag, ".ch"},    32'(ch_o),    32'(got.ch));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //             valid    sel   rdy   data            ready    y      v     ch
    vecs[0] = '{4'b0100, 2'd2, 1'b1, 32'h77A5_5544, 4'b0100, 8'hA5, 1'b1, 2'd2};
    vecs[1] = '{4'b0010, 2'd1, 1'b1, 32'h1122_3C00, 4'b0010, 8'h3C, 1'b1, 2'd1};
    vecs[2] = '{4'b1111, 2'd3, 1'b0, 32'hDEAD_BEEF, 4'b0000, 8'h3C, 1'b1, 2'd1};
    vecs[3] = '{4'b0001, 2'd0, 1'b0, 32'h0102_0304, 4'b0000, 8'h3C, 1'b1, 2'd1};
    vecs[4] = '{4'b1000, 2'd3, 1'b0, 32'h9900_0000, 4'b0000, 8'h3C, 1'b1, 2'd1};
    vecs[5] = '{4'b1000, 2'd3, 1'b1, 32'h9900_0000, 4'b1000, 8'h99, 1'b1, 2'd3};
    vecs[6] = '{4'b0100, 2'd1, 1'b1, 32'h6600_0000, 4'b0000, 8'h99, 1'b0, 2'd3};
    vecs[7] = '{4'b0010, 2'd1, 1'b0, 32'h0000_5A00, 4'b0010, 8'h5A, 1'b1, 2'd1};
    vecs[8] = '{4'b0000, 2'd0, 1'b0, 32'h0000_0000, 4'b0000, 8'h5A, 1'b1, 2'd1};
    vecs[9] = '{4'b0000, 2'd0, 1'b1, 32'h0000_0000, 4'b0000, 8'h5A, 1'b0, 2'd1};
    none    = '{4'b0, 2'd0, 1'b0, 32'h0, 4'b0, 8'h0, 1'b0, 2'd0};

    // Reset held with all channels valid and downstream ready
    reset_n = 1'b0;
    valid_i = 4'hF;
    ready_i = 1'b1;
    mode_i  = 1'b1;
    sel_i   = 2'd0;
    data_i  = 32'h4433_2211;
    modelReset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput("rst.y",     32'(y_o),     32'h00);
      checkOutput("rst.valid", 32'(valid_o), 32'h0);
      checkOutput("rst.ch",    32'(ch_o),    32'h0);
    end
    reset_n = 1'b1;
    applyStimulus(4'hF, 2'd0, 1'b1, 1'b1, 32'h4433_2211, "rst_first", 1'b0, none);

    // Fixed-mode table, including back-pressure and drain-with-load
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].sel, 1'b0, vecs[i].rdy, vecs[i].data,
                    $sformatf("tab%0d", i), 1'b1, vecs[i]);
    end

    // Land a transfer on ch3 so the pointer wraps to 0, then round-robin
    applyStimulus(4'b1000, 2'd3, 1'b0, 1'b1, 32'h4433_2211, "rr_pre", 1'b0, none);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1011, 2'd0, 1'b1, 1'b1, 32'h4433_2211, $sformatf("rr%0d", i), 1'b0, none);
    end

    // Wrap/skip: grant ch2, then only ch0 valid, then nothing valid
    applyStimulus(4'b0100, 2'd2, 1'b1, 1'b1, 32'h4433_2211, "wrap_ch2", 1'b0, none);
    applyStimulus(4'b0001, 2'd0, 1'b1, 1'b1, 32'h4433_2211, "wrap_ch0", 1'b0, none);
    applyStimulus(4'b0000, 2'd0, 1'b1, 1'b1, 32'h4433_2211, "drain", 1'b0, none);
    applyStimulus(4'b1111, 2'd1, 1'b1, 1'b1, 32'h4433_2211, "ptr1", 1'b0, none);

    // Asynchronous reset between edges while a word is held
    ready_i = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst.y",     32'(y_o),     32'h00);
    checkOutput("midrst.valid", 32'(valid_o), 32'h0);
    checkOutput("midrst.ch",    32'(ch_o),    32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    modelReset();
    applyStimulus(4'hF, 2'd0, 1'b1, 1'b1, 32'h4433_2211, "post_rst0", 1'b0, none);
    applyStimulus(4'hF, 2'd0, 1'b1, 1'b1, 32'h4433_2211, "post_rst1", 1'b0, none);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    $urandom, $sformatf("rnd%0d", i), 1'b0, none);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
